uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter with optional parity bit.
module uart_tx #(
   parameter int CPB        = 434,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    din,
   input  logic                          din_valid,
   output logic                          din_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CPB);
   localparam int LW = AW + 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t          state, state_n;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      sh;
   logic            par, push, pop, last, tx_n;
   assign din_ready = level < LW'(FIFO_DEPTH);
   assign push      = din_valid & din_ready;
   assign last      = cnt == CW'(CPB - 1);
   assign busy      = (state != IDLE) | (level != '0);
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      tx_n    = tx;
      case (state)
         IDLE:    if (level != '0) begin
                     pop     = 1'b1;
                     tx_n    = 1'b0;
                     state_n = START;
                  end
         START:   if (last) begin
                     state_n = DATA;
                     tx_n    = sh[0];
                  end
         DATA:    if (last) begin
                     if (idx == 3'd7) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        tx_n    = (PARITY_EN != 0) ? par : 1'b1;
                     end else
                        tx_n = sh[idx + 3'd1];
                  end
         PARITY:  if (last) begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
         STOP:    if (last) begin
                     // back-to-back frames: the next start bit follows the stop bit directly
                     pop     = level != '0;
                     tx_n    = level == '0;
                     state_n = (level != '0) ? START : IDLE;
                  end
         default: begin
                     state_n = IDLE;
                     tx_n    = 1'b1;
                  end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         tx     <= 1'b1;
         level  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         idx    <= '0;
         sh     <= '0;
         par    <= 1'b0;
      end else begin
         state <= state_n;
         tx    <= tx_n;
         cnt   <= (state == IDLE || last) ? '0 : cnt + CW'(1);
         idx   <= (state == DATA && last) ? idx + 3'd1 : idx;
         level <= level + LW'(push) - LW'(pop);
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            sh     <= mem[rd_ptr];
            par    <= ^mem[rd_ptr] ^ (PARITY_ODD != 0);
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end
endmodule
